// File: rtl/stream_pass_pkg.sv
// +----------------------------------------------------------------------+
// | stream_pass_pkg : parameter limits and counter width for stream_pass |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package stream_pass_pkg;

  localparam int MAX_WIDTH    = 64;
  localparam int MAX_CHANNELS = 16;
  localparam int MAX_DEPTH    = 8;
  localparam int CNT_W        = 16;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_pass_stage.sv
// +----------------------------------------------------------------------+
// | stream_pass_stage : one skid slice (main + skid register)            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module stream_pass_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_in_xfer;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_in_xfer = in_valid & r_ready;

  // Skid holds a word only while main is occupied and downstream stalls.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (r_skid_valid) begin
      if (out_ready) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      if (!r_main_valid || out_ready) begin
        w_load_main_in   = 1'b1;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_load_skid      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (out_ready) begin
      w_main_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_ready      <= ~w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_main_in) begin
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
    end
    if (w_load_skid) begin
      r_skid_data <= in_data;
    end
  end

  assign in_ready  = r_ready;
  assign out_data  = r_main_data;
  assign out_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/stream_pass.sv
// +----------------------------------------------------------------------+
// | stream_pass : CHANNELS independent elastic pipelines, DEPTH slices   |
// | each. Optional STREAM_PASS_CNT_EN adds per-channel beat counters.    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module stream_pass
  import stream_pass_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready
`ifdef STREAM_PASS_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] beat_cnt
`endif
);

  if (!in_range(WIDTH, 1, MAX_WIDTH)) begin : g_bad_width
    $error("stream_pass: WIDTH out of range 1..64");
  end
  if (!in_range(CHANNELS, 1, MAX_CHANNELS)) begin : g_bad_channels
    $error("stream_pass: CHANNELS out of range 1..16");
  end
  if (!in_range(DEPTH, 1, MAX_DEPTH)) begin : g_bad_depth
    $error("stream_pass: DEPTH out of range 1..8");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH:0][WIDTH-1:0] w_data;
    logic [DEPTH:0]            w_valid;
    logic [DEPTH:0]            w_ready;

    // Index 0 is the channel input, index DEPTH the channel output.
    assign w_data[0]                    = in_data[c*WIDTH +: WIDTH];
    assign w_valid[0]                   = in_valid[c];
    assign in_ready[c]                  = w_ready[0];
    assign out_data[c*WIDTH +: WIDTH]   = w_data[DEPTH];
    assign out_valid[c]                 = w_valid[DEPTH];
    assign w_ready[DEPTH]               = out_ready[c];

    for (genvar s = 0; s < DEPTH; s++) begin : g_st
      stream_pass_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (w_data[s]),
        .in_valid (w_valid[s]),
        .in_ready (w_ready[s]),
        .out_data (w_data[s+1]),
        .out_valid(w_valid[s+1]),
        .out_ready(w_ready[s+1])
      );
    end

`ifdef STREAM_PASS_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_valid[DEPTH] && out_ready[c]) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end

    assign beat_cnt[c*CNT_W +: CNT_W] = r_cnt;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_pass.sv
// Directed bench for stream_pass (WIDTH=8, CHANNELS=2, DEPTH=2) with an in-order scoreboard.
`default_nettype none

module tb_stream_pass;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int D  = 2;
  localparam int NW = 2000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready;
`ifdef STREAM_PASS_CNT_EN
  logic [CH*16-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  stream_pass #(
    .WIDTH   (W),
    .CHANNELS(CH),
    .DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_PASS_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [CH-1:0] prev_stall;
  logic [W-1:0]  prev_data [CH];
  int            out_cnt [CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push(input int c, input logic [W-1:0] d);
    if (c == 0) q0.push_back(d);
    else        q1.push_back(d);
  endfunction

  function automatic logic [W-1:0] pop(input int c);
    if (c == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Called at a negedge with inputs already driven: score the transfers of
  // the coming rising edge, then advance to the next negedge.
  task automatic step();
    logic [W-1:0] exp_d;
    for (int c = 0; c < CH; c++) begin
      if (prev_stall[c]) begin
        check("hold_valid", 64'(out_valid[c]), 64'd1);
        check("hold_data", 64'(out_data[c*W +: W]), 64'(prev_data[c]));
      end
      if (qsize(c) == 2*D) check("full_ready_low", 64'(in_ready[c]), 64'd0);
      if (out_valid[c] && out_ready[c]) begin
        if (qsize(c) == 0) begin
          check("spurious_out", 64'(out_valid[c]), 64'd0);
        end else begin
          exp_d = pop(c);
          check("order_data", 64'(out_data[c*W +: W]), 64'(exp_d));
        end
        out_cnt[c]++;
      end
      if (in_valid[c] && in_ready[c]) push(c, in_data[c*W +: W]);
      prev_stall[c] = out_valid[c] & ~out_ready[c];
      prev_data[c]  = out_data[c*W +: W];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [CH];
    int accepts;
    int drops;
    int seen [CH];
    int gaps [CH];
    int sent [CH];
    bit done;
    logic [7:0] b;

    rst_n      = 1'b0;
    in_valid   = '0;
    out_ready  = '0;
    in_data    = '0;
    prev_stall = '0;
    for (int c = 0; c < CH; c++) begin
      out_cnt[c]   = 0;
      prev_data[c] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef STREAM_PASS_CNT_EN
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd3);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Latency: 0x5A accepted at edge N, presented for its output transfer at edge N+DEPTH.
    out_ready = 2'b11;
    in_valid  = 2'b01;
    in_data   = 16'h005A;
    check("lat_in_ready", 64'(in_ready[0]), 64'd1);
    step();
    in_valid = '0;
    check("lat_not_yet", 64'(out_valid[0]), 64'd0);
    step();
    check("lat_valid", 64'(out_valid[0]), 64'd1);
    check("lat_data", 64'(out_data[7:0]), 64'h5A);
    step();
    check("lat_drained", 64'(out_valid[0]), 64'd0);

    // Throughput: 100 back-to-back words on both channels.
    drops = 0;
    for (int c = 0; c < CH; c++) begin
      base[c] = out_cnt[c];
      seen[c] = 0;
      gaps[c] = 0;
    end
    for (int i = 0; i < 100 + D + 2; i++) begin
      b        = 8'(i);
      in_valid = (i < 100) ? 2'b11 : 2'b00;
      in_data  = {~b, b};
      if (i < 100 && in_ready != 2'b11) drops++;
      for (int c = 0; c < CH; c++) begin
        if (out_valid[c]) seen[c]++;
        else if (seen[c] > 0 && seen[c] < 100) gaps[c]++;
      end
      step();
    end
    check("tp_ready_drops", 64'(drops), 64'd0);
    for (int c = 0; c < CH; c++) begin
      check("tp_count", 64'(out_cnt[c] - base[c]), 64'd100);
      check("tp_gaps", 64'(gaps[c]), 64'd0);
      check("tp_queue_empty", 64'(qsize(c)), 64'd0);
    end

    // Backpressure on ch0 only; ch1 keeps streaming.
    out_ready = 2'b10;
    in_valid  = 2'b11;
    accepts   = 0;
    drops     = 0;
    base[0]   = out_cnt[0];
    base[1]   = out_cnt[1];
    for (int k = 0; k < 8; k++) begin
      in_data = {8'(8'h80 + k), 8'(8'h10 + k)};
      if (in_ready[0]) accepts++;
      if (!in_ready[1]) drops++;
      step();
    end
    check("bp_accepts", 64'(accepts), 64'd4);
    check("bp_ready_low", 64'(in_ready[0]), 64'd0);
    check("bp_ch1_ready_drops", 64'(drops), 64'd0);
    check("bp_ch1_outputs", 64'(out_cnt[1] - base[1]), 64'd6);
    check("bp_ch0_held", 64'(out_cnt[0] - base[0]), 64'd0);
    in_valid  = '0;
    out_ready = 2'b11;
    repeat (6) step();
    check("bp_drain_count", 64'(out_cnt[0] - base[0]), 64'd4);
    check("bp_drain_empty", 64'(qsize(0)), 64'd0);

    // Random stress at 50% valid/ready density.
    for (int c = 0; c < CH; c++) begin
      base[c] = out_cnt[c];
      sent[c] = 0;
    end
    done = 1'b0;
    for (int k = 0; k < 30000 && !done; k++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c]  = (sent[c] < NW) ? 1'($urandom_range(0, 1)) : 1'b0;
        out_ready[c] = 1'($urandom_range(0, 1));
      end
      in_data = 16'($urandom);
      for (int c = 0; c < CH; c++) begin
        if (in_valid[c] && in_ready[c]) sent[c]++;
      end
      step();
      done = (sent[0] == NW) && (sent[1] == NW) && (q0.size() == 0) && (q1.size() == 0);
    end
    check("stress_done", 64'(done), 64'd1);
    for (int c = 0; c < CH; c++) begin
      check("stress_count", 64'(out_cnt[c] - base[c]), 64'(NW));
    end

    // Reset with three words in flight on ch0.
    in_valid  = 2'b01;
    out_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      in_data = {8'h00, 8'(8'hA1 + k)};
      step();
    end
    in_valid = '0;
    check("mid_inflight", 64'(q0.size()), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    q0.delete();
    q1.delete();
    prev_stall = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 2'b11;
    step();
    check("mid_rel_in_ready", 64'(in_ready), 64'd3);
    for (int k = 0; k < 4; k++) begin
      check("mid_no_stale", 64'(out_valid), 64'd0);
      step();
    end
    in_valid = 2'b01;
    in_data  = 16'h00C3;
    step();
    in_valid = '0;
    check("mid_lat_not_yet", 64'(out_valid[0]), 64'd0);
    step();
    check("mid_lat_valid", 64'(out_valid[0]), 64'd1);
    check("mid_lat_data", 64'(out_data[7:0]), 64'hC3);
    step();

`ifdef STREAM_PASS_CNT_EN
    // Counter wrap: 65537 transfers on ch0 leave 0x0001; ch1 untouched.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cnt_rst", 64'(beat_cnt), 64'd0);
    q0.delete();
    q1.delete();
    prev_stall = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    accepts   = 0;
    out_ready = 2'b11;
    for (int k = 0; k < 70000 && accepts < 65537; k++) begin
      in_valid = 2'b01;
      in_data  = {8'h00, 8'(k)};
      if (in_ready[0]) accepts++;
      step();
    end
    in_valid = '0;
    repeat (D + 2) step();
    check("cnt_accepts", 64'(accepts), 64'd65537);
    check("cnt_ch0_wrap", 64'(beat_cnt[15:0]), 64'h0001);
    check("cnt_ch1_unchanged", 64'(beat_cnt[31:16]), 64'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
